// File: rtl/ex_stage_mc.sv
// Execute stage: operand/store forwarding, single-cycle ALU, registered EX/MEM outputs.
// Optional feature macro EX_MUL_EN adds an iterative shift-add multiplier (cmd 8) with busy handshake.
module ex_stage_mc #(
  parameter int DW  = 16,
  parameter int RW  = 3,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           stall_in,
  input  logic           flush,
  input  logic           in_valid,
  input  logic [OPW-1:0] opcode_in,
  input  logic [3:0]     cmd,
  input  logic [1:0]     fwd_sel_a,
  input  logic [1:0]     fwd_sel_b,
  input  logic [1:0]     fwd_sel_st,
  input  logic [DW-1:0]  fwd_res_ex,
  input  logic [DW-1:0]  fwd_res_mem,
  input  logic [DW-1:0]  fwd_res_wb,
  input  logic [DW-1:0]  rs_a,
  input  logic [DW-1:0]  rs_b,
  input  logic [DW-1:0]  store_data_in,
  input  logic [RW-1:0]  op_dest_in,
  input  logic           mem_write_en_in,
  input  logic           wb_mux_in,
  input  logic           wb_en_in,
  output logic           busy,
  output logic           ex_valid,
  output logic [DW-1:0]  alu_res,
  output logic [DW-1:0]  ex_store_data,
  output logic [RW-1:0]  ex_op_dest,
  output logic           ex_mem_write_en,
  output logic           ex_wb_mux,
  output logic           ex_wb_en,
  output logic [OPW-1:0] ex_opcode
);

  localparam int SW = $clog2(DW);

  localparam logic [3:0] CMD_ADD = 4'd0;
  localparam logic [3:0] CMD_SUB = 4'd1;
  localparam logic [3:0] CMD_AND = 4'd2;
  localparam logic [3:0] CMD_OR  = 4'd3;
  localparam logic [3:0] CMD_XOR = 4'd4;
  localparam logic [3:0] CMD_SLL = 4'd5;
  localparam logic [3:0] CMD_SRL = 4'd6;
  localparam logic [3:0] CMD_SRA = 4'd7;
  localparam logic [3:0] CMD_MUL = 4'd8;

  function automatic logic [DW-1:0] fwd_pick(input logic [1:0] sel,
                                             input logic [DW-1:0] reg_val,
                                             input logic [DW-1:0] ex_val,
                                             input logic [DW-1:0] mem_val,
                                             input logic [DW-1:0] wb_val);
    logic [DW-1:0] r;
    case (sel)
      2'b10:   r = ex_val;
      2'b11:   r = mem_val;
      2'b01:   r = wb_val;
      default: r = reg_val;
    endcase
    return r;
  endfunction

  // cmd 8 yields 0 here; when the multiplier exists it is taken by the FSM instead.
  function automatic logic [DW-1:0] alu_calc(input logic [3:0] op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [SW-1:0] sh;
    logic [DW-1:0] r;
    sh = b[SW-1:0];
    case (op)
      CMD_ADD: r = a + b;
      CMD_SUB: r = a - b;
      CMD_AND: r = a & b;
      CMD_OR:  r = a | b;
      CMD_XOR: r = a ^ b;
      CMD_SLL: r = a << sh;
      CMD_SRL: r = a >> sh;
      CMD_SRA: r = $signed(a) >>> sh;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [DW-1:0]  op_a_s, op_b_s, st_s, alu_s;
  logic           single_load_s, done_load_s, load_en_s;
  logic [DW-1:0]  ld_res_s, ld_st_s;
  logic [RW-1:0]  ld_dest_s;
  logic [OPW-1:0] ld_opc_s;
  logic           ld_mwe_s, ld_wbm_s, ld_wbe_s, ld_valid_s;

  assign op_a_s = fwd_pick(fwd_sel_a, rs_a, fwd_res_ex, fwd_res_mem, fwd_res_wb);
  assign op_b_s = fwd_pick(fwd_sel_b, rs_b, fwd_res_ex, fwd_res_mem, fwd_res_wb);
  assign st_s   = fwd_pick(fwd_sel_st, store_data_in, fwd_res_ex, fwd_res_mem, fwd_res_wb);
  assign alu_s  = alu_calc(cmd, op_a_s, op_b_s);

`ifdef EX_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [SW-1:0] CNT_LAST = SW'(DW - 1);

  state_t         state_r, state_nx_s;
  logic [DW-1:0]  mcand_r, mplier_r, acc_r, hold_st_r;
  logic [SW-1:0]  cnt_r;
  logic [RW-1:0]  hold_dest_r;
  logic [OPW-1:0] hold_opc_r;
  logic           hold_mwe_r, hold_wbm_r, hold_wbe_r;
  logic           is_idle_s, mul_accept_s;

  assign is_idle_s     = (state_r == ST_IDLE);
  assign mul_accept_s  = is_idle_s & in_valid & (cmd == CMD_MUL) & ~stall_in & ~flush;
  assign done_load_s   = (state_r == ST_DONE) & ~stall_in & ~flush;
  assign single_load_s = is_idle_s & ~stall_in & ~flush & ~mul_accept_s;
  assign busy = rst_n & (mul_accept_s | (state_r == ST_MUL) |
                         ((state_r == ST_DONE) & stall_in));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next state; flush always returns to IDLE
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nx_s = mul_accept_s ? ST_MUL : ST_IDLE;
        ST_MUL:  state_nx_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_MUL;
        ST_DONE: state_nx_s = stall_in ? ST_DONE : ST_IDLE;
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Multiplier operands, accumulator and held sideband
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc_r       <= '0;
      cnt_r       <= '0;
      hold_st_r   <= '0;
      hold_dest_r <= '0;
      hold_opc_r  <= '0;
      hold_mwe_r  <= 1'b0;
      hold_wbm_r  <= 1'b0;
      hold_wbe_r  <= 1'b0;
    end else if (mul_accept_s) begin
      mcand_r     <= op_a_s;
      mplier_r    <= op_b_s;
      acc_r       <= '0;
      cnt_r       <= '0;
      hold_st_r   <= st_s;
      hold_dest_r <= op_dest_in;
      hold_opc_r  <= opcode_in;
      hold_mwe_r  <= mem_write_en_in;
      hold_wbm_r  <= wb_mux_in;
      hold_wbe_r  <= wb_en_in;
    end else if (state_r == ST_MUL) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= {mcand_r[DW-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[DW-1:1]};
      cnt_r    <= cnt_r + SW'(1);
    end
  end

  // EX/MEM load source: finished product or the current single-cycle op
  always_comb begin
    load_en_s  = single_load_s | done_load_s;
    ld_res_s   = alu_s;
    ld_st_s    = st_s;
    ld_dest_s  = op_dest_in;
    ld_opc_s   = opcode_in;
    ld_mwe_s   = mem_write_en_in & in_valid;
    ld_wbm_s   = wb_mux_in;
    ld_wbe_s   = wb_en_in & in_valid;
    ld_valid_s = in_valid;
    if (done_load_s) begin
      ld_res_s   = acc_r;
      ld_st_s    = hold_st_r;
      ld_dest_s  = hold_dest_r;
      ld_opc_s   = hold_opc_r;
      ld_mwe_s   = hold_mwe_r;
      ld_wbm_s   = hold_wbm_r;
      ld_wbe_s   = hold_wbe_r;
      ld_valid_s = 1'b1;
    end else begin
      ld_valid_s = in_valid;
    end
  end
`else
  assign single_load_s = ~stall_in & ~flush;
  assign done_load_s   = 1'b0;
  assign busy          = 1'b0;

  // EX/MEM load source: current single-cycle op only
  always_comb begin
    load_en_s  = single_load_s;
    ld_res_s   = alu_s;
    ld_st_s    = st_s;
    ld_dest_s  = op_dest_in;
    ld_opc_s   = opcode_in;
    ld_wbm_s   = wb_mux_in;
    if (in_valid) begin
      ld_mwe_s   = mem_write_en_in;
      ld_wbe_s   = wb_en_in;
      ld_valid_s = 1'b1;
    end else begin
      ld_mwe_s   = 1'b0;
      ld_wbe_s   = 1'b0;
      ld_valid_s = 1'b0;
    end
  end
`endif

  // EX/MEM pipeline register; flush clears only the qualifying bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      alu_res         <= '0;
      ex_store_data   <= '0;
      ex_op_dest      <= '0;
      ex_mem_write_en <= 1'b0;
      ex_wb_mux       <= 1'b0;
      ex_wb_en        <= 1'b0;
      ex_opcode       <= '0;
    end else if (flush) begin
      ex_valid        <= 1'b0;
      ex_wb_en        <= 1'b0;
      ex_mem_write_en <= 1'b0;
    end else if (load_en_s) begin
      ex_valid        <= ld_valid_s;
      alu_res         <= ld_res_s;
      ex_store_data   <= ld_st_s;
      ex_op_dest      <= ld_dest_s;
      ex_mem_write_en <= ld_mwe_s;
      ex_wb_mux       <= ld_wbm_s;
      ex_wb_en        <= ld_wbe_s;
      ex_opcode       <= ld_opc_s;
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: vector table, randomized run against a
// behavioural model, and multi-cycle sequences (multiplier ones need EX_MUL_EN).
`timescale 1ns/1ps
module tb_ex_stage_mc;
  localparam int DW  = 16;
  localparam int RW  = 3;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst_n, stall_in, flush, in_valid;
  logic [OPW-1:0] opcode_in;
  logic [3:0]     cmd;
  logic [1:0]     fwd_sel_a, fwd_sel_b, fwd_sel_st;
  logic [DW-1:0]  fwd_res_ex, fwd_res_mem, fwd_res_wb, rs_a, rs_b, store_data_in;
  logic [RW-1:0]  op_dest_in;
  logic           mem_write_en_in, wb_mux_in, wb_en_in;
  logic           busy, ex_valid, ex_mem_write_en, ex_wb_mux, ex_wb_en;
  logic [DW-1:0]  alu_res, ex_store_data;
  logic [RW-1:0]  ex_op_dest;
  logic [OPW-1:0] ex_opcode;

  ex_stage_mc #(.DW(DW), .RW(RW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush), .in_valid(in_valid),
    .opcode_in(opcode_in), .cmd(cmd), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_sel_st(fwd_sel_st), .fwd_res_ex(fwd_res_ex), .fwd_res_mem(fwd_res_mem),
    .fwd_res_wb(fwd_res_wb), .rs_a(rs_a), .rs_b(rs_b), .store_data_in(store_data_in),
    .op_dest_in(op_dest_in), .mem_write_en_in(mem_write_en_in), .wb_mux_in(wb_mux_in),
    .wb_en_in(wb_en_in), .busy(busy), .ex_valid(ex_valid), .alu_res(alu_res),
    .ex_store_data(ex_store_data), .ex_op_dest(ex_op_dest),
    .ex_mem_write_en(ex_mem_write_en), .ex_wb_mux(ex_wb_mux), .ex_wb_en(ex_wb_en),
    .ex_opcode(ex_opcode)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected EX/MEM contents
  logic [15:0] m_res, m_st;
  logic [2:0]  m_dest;
  logic [3:0]  m_opc;
  logic        m_mwe, m_wbm, m_wbe, m_valid;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[16];
  int   nvec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_fwd(input logic [1:0] sel, input logic [15:0] regv);
    if (sel == 2'b10) return fwd_res_ex;
    if (sel == 2'b11) return fwd_res_mem;
    if (sel == 2'b01) return fwd_res_wb;
    return regv;
  endfunction

  function automatic logic [15:0] ref_alu(input logic [3:0] c, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned sh;
    logic [15:0] r;
    sh = int'(b[3:0]);
    case (c)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = $signed(a) >>> sh;
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    stall_in = 1'b0; flush = 1'b0; in_valid = 1'b0; cmd = 4'd0; opcode_in = 4'd0;
    fwd_sel_a = 2'b00; fwd_sel_b = 2'b00; fwd_sel_st = 2'b00;
    fwd_res_ex = 16'h0; fwd_res_mem = 16'h0; fwd_res_wb = 16'h0;
    rs_a = 16'h0; rs_b = 16'h0; store_data_in = 16'h0; op_dest_in = 3'd0;
    mem_write_en_in = 1'b0; wb_mux_in = 1'b0; wb_en_in = 1'b0;
  endtask

  // what the EX/MEM register should hold after the coming edge (single-cycle ops)
  task automatic model_edge();
    if (flush) begin
      m_valid = 1'b0; m_wbe = 1'b0; m_mwe = 1'b0;
    end else if (!stall_in) begin
      m_res   = ref_alu(cmd, ref_fwd(fwd_sel_a, rs_a), ref_fwd(fwd_sel_b, rs_b));
      m_st    = ref_fwd(fwd_sel_st, store_data_in);
      m_dest  = op_dest_in;
      m_opc   = opcode_in;
      m_wbm   = wb_mux_in;
      m_wbe   = wb_en_in & in_valid;
      m_mwe   = mem_write_en_in & in_valid;
      m_valid = in_valid;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".alu_res"}, alu_res, m_res);
    chk({tag, ".store"}, ex_store_data, m_st);
    chk({tag, ".dest"}, ex_op_dest, m_dest);
    chk({tag, ".opcode"}, ex_opcode, m_opc);
    chk({tag, ".mwe"}, ex_mem_write_en, m_mwe);
    chk({tag, ".wbmux"}, ex_wb_mux, m_wbm);
    chk({tag, ".wben"}, ex_wb_en, m_wbe);
    chk({tag, ".valid"}, ex_valid, m_valid);
  endtask

  task automatic add_vec(input logic [3:0] c, input logic [1:0] sa, input logic [1:0] sb,
                         input logic [15:0] ra, input logic [15:0] rb, input logic [15:0] e);
    vecs[nvec] = '{c, sa, sb, ra, rb, e};
    nvec++;
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, ".alu_now"}, alu_res, 16'h0);
    chk({tag, ".valid_now"}, ex_valid, 1'b0);
    chk({tag, ".wben_now"}, ex_wb_en, 1'b0);
    chk({tag, ".store_now"}, ex_store_data, 16'h0);
    chk({tag, ".opc_now"}, ex_opcode, 4'h0);
    chk({tag, ".busy_now"}, busy, 1'b0);
    tick();
    chk({tag, ".busy_held"}, busy, 1'b0);
    rst_n = 1'b1;
    m_res = 16'h0; m_st = 16'h0; m_dest = 3'd0; m_opc = 4'd0;
    m_mwe = 1'b0; m_wbm = 1'b0; m_wbe = 1'b0; m_valid = 1'b0;
  endtask

  task automatic issue_add(input logic [15:0] a, input logic [15:0] b);
    idle_inputs();
    cmd = 4'd0; in_valid = 1'b1; wb_en_in = 1'b1; rs_a = a; rs_b = b;
    tick();
  endtask

`ifdef EX_MUL_EN
  task automatic mul_inputs(input logic [15:0] a, input logic [15:0] b);
    idle_inputs();
    cmd = 4'd8; in_valid = 1'b1; rs_a = a; rs_b = b; store_data_in = 16'h5A5A;
    op_dest_in = 3'd5; opcode_in = 4'hC; wb_en_in = 1'b1; wb_mux_in = 1'b1;
  endtask

  task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input int nst,
                        input string tag);
    logic [31:0] full;
    logic [15:0] pre;
    int bc;
    bit got;
    full = 32'(a) * 32'(b);
    issue_add(16'h0700, 16'h0077);
    pre = alu_res;
    mul_inputs(a, b);
    bc = 0;
    got = 1'b0;
    for (int c = 0; c < 60; c++) begin
      stall_in = (c >= 17 && c < 17 + nst);
      #1;
      if (!busy) begin
        tick();
        got = 1'b1;
        break;
      end
      bc++;
      tick();
      chk({tag, ".frozen"}, alu_res, pre);
    end
    chk({tag, ".completed"}, got, 1'b1);
    chk({tag, ".busy_cycles"}, bc, 17 + nst);
    chk({tag, ".product"}, alu_res, full[15:0]);
    chk({tag, ".valid"}, ex_valid, 1'b1);
    chk({tag, ".wben"}, ex_wb_en, 1'b1);
    chk({tag, ".dest"}, ex_op_dest, 3'd5);
    chk({tag, ".opcode"}, ex_opcode, 4'hC);
    chk({tag, ".store"}, ex_store_data, 16'h5A5A);
    idle_inputs();
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    m_res = 16'h0; m_st = 16'h0; m_dest = 3'd0; m_opc = 4'd0;
    m_mwe = 1'b0; m_wbm = 1'b0; m_wbe = 1'b0; m_valid = 1'b0;
    tick();
    tick();
    check_all("reset");
    chk("reset.busy", busy, 1'b0);
    rst_n = 1'b1;

    // single-cycle ALU table; forwarding sources: EX=0005, MEM=BEEF, WB=00F0
    nvec = 0;
    add_vec(4'd0,  2'b10, 2'b00, 16'h1111, 16'h0003, 16'h0008);
    add_vec(4'd1,  2'b00, 2'b00, 16'h0003, 16'h0005, 16'hFFFE);
    add_vec(4'd2,  2'b11, 2'b00, 16'h0000, 16'h0FF0, 16'h0EE0);
    add_vec(4'd3,  2'b01, 2'b00, 16'h0000, 16'h0F00, 16'h0FF0);
    add_vec(4'd4,  2'b00, 2'b11, 16'h1234, 16'h0000, 16'hACDB);
    add_vec(4'd5,  2'b00, 2'b00, 16'h0001, 16'h0013, 16'h0008);
    add_vec(4'd5,  2'b00, 2'b00, 16'h0003, 16'h000F, 16'h8000);
    add_vec(4'd6,  2'b00, 2'b00, 16'h8000, 16'h0004, 16'h0800);
    add_vec(4'd7,  2'b00, 2'b00, 16'h8000, 16'h0004, 16'hF800);
    add_vec(4'd7,  2'b00, 2'b00, 16'h7000, 16'h0014, 16'h0700);
    add_vec(4'd15, 2'b00, 2'b00, 16'h1234, 16'h5678, 16'h0000);
`ifndef EX_MUL_EN
    add_vec(4'd8,  2'b00, 2'b00, 16'h0003, 16'h0005, 16'h0000);
`endif
    for (int i = 0; i < nvec; i++) begin
      idle_inputs();
      fwd_res_ex = 16'h0005; fwd_res_mem = 16'hBEEF; fwd_res_wb = 16'h00F0;
      cmd = vecs[i].cmd; fwd_sel_a = vecs[i].sa; fwd_sel_b = vecs[i].sb;
      rs_a = vecs[i].ra; rs_b = vecs[i].rb; in_valid = 1'b1; wb_en_in = 1'b1;
      #1;
      chk($sformatf("vec%0d.busy", i), busy, 1'b0);
      model_edge();
      tick();
      chk($sformatf("vec%0d.alu_res", i), alu_res, vecs[i].exp);
      chk($sformatf("vec%0d.valid", i), ex_valid, 1'b1);
      chk($sformatf("vec%0d.wben", i), ex_wb_en, 1'b1);
    end

    // invalid input is a bubble
    idle_inputs();
    cmd = 4'd0; fwd_sel_a = 2'b10; fwd_res_ex = 16'h0005; rs_b = 16'h0003; wb_en_in = 1'b1;
    mem_write_en_in = 1'b1;
    model_edge();
    tick();
    chk("bubble.valid", ex_valid, 1'b0);
    chk("bubble.wben", ex_wb_en, 1'b0);
    chk("bubble.mwe", ex_mem_write_en, 1'b0);

    // store data forwarding from each source
    for (int s = 0; s < 4; s++) begin
      idle_inputs();
      in_valid = 1'b1; mem_write_en_in = 1'b1; fwd_sel_st = 2'(s);
      fwd_res_ex = 16'hCAFE; fwd_res_mem = 16'hBEEF; fwd_res_wb = 16'h2222;
      store_data_in = 16'h1111; op_dest_in = 3'(s + 1); opcode_in = 4'(s + 4);
      model_edge();
      tick();
      check_all($sformatf("store%0d", s));
    end

    // stall holds everything, flush clears only the qualifying bits
    idle_inputs();
    stall_in = 1'b1; in_valid = 1'b1; cmd = 4'd4; rs_a = 16'hFFFF; wb_en_in = 1'b1;
    model_edge();
    tick();
    tick();
    check_all("stall");
    chk("stall.busy", busy, 1'b0);
    stall_in = 1'b0; flush = 1'b1;
    model_edge();
    tick();
    check_all("flush");
    flush = 1'b0;

    // randomized stream against the model
    for (int n = 0; n < 300; n++) begin
      idle_inputs();
      stall_in = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      cmd = 4'($urandom_range(0, 15));
`ifdef EX_MUL_EN
      if (cmd == 4'd8) cmd = 4'd9;
`endif
      fwd_sel_a = 2'($urandom); fwd_sel_b = 2'($urandom); fwd_sel_st = 2'($urandom);
      fwd_res_ex = 16'($urandom); fwd_res_mem = 16'($urandom); fwd_res_wb = 16'($urandom);
      rs_a = 16'($urandom); rs_b = 16'($urandom); store_data_in = 16'($urandom);
      op_dest_in = 3'($urandom); opcode_in = 4'($urandom);
      mem_write_en_in = 1'($urandom); wb_mux_in = 1'($urandom); wb_en_in = 1'($urandom);
      #1;
      chk("rand.busy", busy, 1'b0);
      model_edge();
      tick();
      check_all($sformatf("rand%0d", n));
    end

`ifdef EX_MUL_EN
    do_mul(16'h0012, 16'h0034, 0, "mul1");
    do_mul(16'h1234, 16'h0100, 0, "mul2");
    do_mul(16'h00FF, 16'h0101, 3, "mulstall");

    // flush during the multiply, then an SRA issues normally
    issue_add(16'h0001, 16'h0002);
    mul_inputs(16'h0003, 16'h0005);
    tick();
    for (int c = 1; c < 6; c++) tick();
    idle_inputs();
    flush = 1'b1; cmd = 4'd7; in_valid = 1'b1; wb_en_in = 1'b1;
    rs_a = 16'h8000; rs_b = 16'h0004;
    #1;
    chk("mulflush.busy_before", busy, 1'b1);
    tick();
    chk("mulflush.valid", ex_valid, 1'b0);
    chk("mulflush.wben", ex_wb_en, 1'b0);
    chk("mulflush.alu_hold", alu_res, 16'h0003);
    flush = 1'b0;
    #1;
    chk("mulflush.busy_after", busy, 1'b0);
    tick();
    chk("mulflush.sra", alu_res, 16'hF800);
    chk("mulflush.sra_valid", ex_valid, 1'b1);
    stall_in = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    chk("mulflush.no_late_product", alu_res, 16'hF800);
    chk("mulflush.idle_busy", busy, 1'b0);

    // reset in the middle of a multiply
    issue_add(16'h0100, 16'h0200);
    mul_inputs(16'h0012, 16'h0034);
    for (int c = 0; c < 4; c++) tick();
    async_reset_check("rstmul");
`else
    async_reset_check("rst");
`endif

    idle_inputs();
    cmd = 4'd0; fwd_sel_a = 2'b10; fwd_res_ex = 16'h0005; rs_b = 16'h0003;
    in_valid = 1'b1; wb_en_in = 1'b1;
    #1;
    chk("postrst.busy", busy, 1'b0);
    tick();
    chk("postrst.alu", alu_res, 16'h0008);
    chk("postrst.valid", ex_valid, 1'b1);
    chk("postrst.wben", ex_wb_en, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised execute stage between the ID/EX and EX/MEM pipeline registers.
- Selects operands and store data from register values or three forwarding sources (EX, MEM, WB).
- Runs single-cycle ALU ops, plus an iterative shift-add multiplier that stalls upstream through a busy handshake.
- Adds a valid bit, a flush input and a multi-cycle op FSM; registers all results and sideband fields into EX/MEM.

Parameters:
DW, 16, datapath width (power of 2, >=8)
RW, 3, destination register index width
OPW, 4, opcode width carried down the pipe

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stall_in  in  1  downstream (memory) not ready; freeze EX/MEM register
flush  in  1  synchronous squash of the in-flight op
in_valid  in  1  ID/EX holds a real instruction
opcode_in  in  OPW  opcode passed through
cmd  in  4  ALU command
fwd_sel_a, fwd_sel_b, fwd_sel_st  in  2 each  operand/store source: 2'b10 EX, 2'b11 MEM, 2'b01 WB, 2'b00 register
fwd_res_ex, fwd_res_mem, fwd_res_wb  in  DW each  forwarded results
rs_a, rs_b, store_data_in  in  DW each  register-file values
op_dest_in  in  RW  destination register
mem_write_en_in, wb_mux_in, wb_en_in  in  1 each  control sideband
busy  out  1  upstream must hold ID/EX
ex_valid  out  1  EX/MEM holds a real instruction
alu_res, ex_store_data  out  DW each  result, store data after forwarding
ex_op_dest  out  RW  destination register
ex_mem_write_en, ex_wb_mux, ex_wb_en  out  1 each  registered sideband
ex_opcode  out  OPW  registered opcode

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, FSM IDLE, counter 0, busy 0. Applies mid-multiply; the op is lost.
- Operand mux: combinational, same encoding for A, B and store data; 00 selects the register value.
- cmd values:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: results mod 2^DW.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is B[log2(DW)-1:0].
  - 8 MUL: low DW bits of A*B.
  - 9-15: reserved; result 0, single cycle.
- FSM states: IDLE, MUL, DONE.
- IDLE, with !flush and !stall_in, at each edge:
  - Single-cycle cmd: capture result, forwarded store data and sideband.
  - ex_valid <= in_valid.
  - ex_wb_en and ex_mem_write_en are gated by in_valid, so an invalid input produces a bubble.
- IDLE, accept of MUL (in_valid & cmd==8 & !stall_in & !flush):
  - Capture forwarded A, B, store data and sideband into internal holding registers; clear the accumulator and counter.
  - Go to MUL. EX/MEM outputs are not updated at this edge.
- MUL: one shift-add step per edge regardless of stall_in; after DW steps go to DONE. Upstream inputs are ignored in this state.
- DONE: if !stall_in, load the product and held fields into EX/MEM, set ex_valid=1, go to IDLE. If stall_in, remain in DONE.
- busy = (IDLE & MUL accept condition) | MUL | (DONE & stall_in).
  - With no stall, busy is high for DW+1 cycles.
  - The result lands at accept edge + DW+1; upstream advances on that same edge.
- stall_in in IDLE: all outputs hold, nothing is accepted, busy 0.
- flush (any state) has priority over stall_in and accept:
  - Next edge: FSM to IDLE; ex_valid, ex_wb_en and ex_mem_write_en cleared.
  - alu_res, ex_store_data, ex_op_dest, ex_wb_mux and ex_opcode hold.
- Reset or flush while in MUL or DONE discards the multiply; no result is ever emitted for it.

Optional Feature:
EX_MUL_EN:
- Defined: MUL path and FSM as above.
- Undefined:
  - cmd 8 is reserved (result 0, single cycle); no MUL/DONE states, holding registers or counter.
  - busy is tied to 0; stage is purely single-cycle.

Test Plan:
- Assert rst_n=0 mid-MUL (cycle 5) -> outputs immediately 0, busy 0; after release an ADD issues normally.
- ADD, fwd_sel_a=10 with fwd_res_ex=0x0005, rs_b=0x0003, wb_en_in=1 -> next edge: alu_res=0x0008, ex_valid=1, ex_wb_en=1. Repeat with in_valid=0 -> ex_valid=0, ex_wb_en=0.
- MUL 0x0012*0x0034 (DW=16) -> busy high 17 cycles; alu_res=0x03A8 and ex_valid=1 at accept+17. MUL 0x1234*0x0100 -> 0x3400.
- MUL with stall_in held 3 cycles on entering DONE -> busy stays 1, outputs frozen; result appears on the first edge with stall_in=0.
- flush at MUL step 6 -> next edge IDLE, ex_valid=0, ex_wb_en=0, busy 0; a following SRA 0x8000 by 4 yields 0xF800 one edge later.
- Store forwarding: fwd_sel_st=11, fwd_res_mem=0xBEEF, store_data_in=0x1111, mem_write_en_in=1 -> ex_store_data=0xBEEF, ex_mem_write_en=1. Build without EX_MUL_EN, cmd=8 -> alu_res=0, busy never 1.
